// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier and its
// neighbours: FSM encoding and iteration/counter sizing.
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  localparam int MUL_ITER = 32;
  localparam int CNT_W    = 5;

endpackage : mul_pkg

// File: rtl/cla32.sv
// 32-bit carry look-ahead adder: 4-bit lookahead groups chained through
// group generate/propagate terms.
module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [7:0]  grp_g;
  logic [7:0]  grp_p;
  logic [8:0]  grp_c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    grp_c    = '0;
    grp_g    = '0;
    grp_p    = '0;
    c        = '0;
    grp_c[0] = ci;
    for (int k = 0; k < 8; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k]   = &p[4*k +: 4];
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);

      c[4*k]   = grp_c[k];
      c[4*k+1] = g[4*k] | (p[4*k] & grp_c[k]);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & grp_c[k]);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
    end
  end

  assign s  = p ^ c;
  assign co = grp_c[8];

endmodule : cla32

// File: rtl/mul32_seq.sv
// Radix-2 shift-and-add 32x32 unsigned multiplier, one partial-product add
// per clock through cla32, with a start/done handshake.
module mul32_seq
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        op_start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic [63:0] result,
  output logic        op_done,
  output logic        busy
);

  mul_state_e       state_q,   state_d;
  logic [31:0]      a_q,       a_d;
  logic [64:0]      p_q,       p_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic [63:0]      result_q,  result_d;
  logic             op_done_q, op_done_d;
  logic             busy_q,    busy_d;

  logic [31:0]      sum;
  logic             carry;

  cla32 u_add (
    .a  (p_q[63:32]),
    .b  (a_q),
    .ci (1'b0),
    .s  (sum),
    .co (carry)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    p_d       = p_q;
    count_d   = count_q;
    result_d  = result_q;
    op_done_d = 1'b0;
    busy_d    = busy_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (op_start) begin
          state_d = ST_EXEC;
          a_d     = multiplicand;
          p_d     = {33'b0, multiplier};
          count_d = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_EXEC: begin
        // Adder carry lands in bit 63 so the 64-bit product never overflows.
        if (p_q[0]) p_d = {1'b0, carry, sum, p_q[31:1]};
        else        p_d = p_q >> 1;
        count_d = count_q + 1'b1;
        busy_d  = 1'b1;
        if (count_q == CNT_W'(MUL_ITER - 1)) begin
          state_d   = ST_DONE;
          result_d  = p_d[63:0];
          op_done_d = 1'b1;
          busy_d    = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      p_q       <= '0;
      count_q   <= '0;
      result_q  <= '0;
      op_done_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      p_q       <= p_d;
      count_q   <= count_d;
      result_q  <= result_d;
      op_done_q <= op_done_d;
      busy_q    <= busy_d;
    end
  end

  assign result  = result_q;
  assign op_done = op_done_q;
  assign busy    = busy_q;

endmodule : mul32_seq

// File: tb/tb_mul32_seq.sv
// Self-checking bench for mul32_seq: directed corners plus random operands
// checked against plain 64-bit multiplication.
module tb_mul32_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [63:0] result;
  logic        op_done;
  logic        busy;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [63:0] last_result = '0;

  always #5 clk = ~clk;

  mul32_seq dut (
    .clk          (clk),
    .reset        (reset),
    .op_start     (op_start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .result       (result),
    .op_done      (op_done),
    .busy         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation: checks busy/hold every cycle, latency, product, pulse width.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] expected;
    int          lat;
    expected     = {32'b0, a} * {32'b0, b};
    multiplicand = a;
    multiplier   = b;
    op_start     = 1'b1;
    tick();
    op_start     = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (op_done === 1'b1) begin
        lat = i;
        break;
      end
      n_vec++;
      if (busy !== 1'b1 || result !== last_result) begin
        n_bad++;
        $display("FAIL %s exec_cycle_%0d: busy=%b result=%h, expected busy=1 result=%h",
                 tag, i, busy, result, last_result);
      end
    end
    n_vec++;
    if (lat != 32) begin
      n_bad++;
      $display("FAIL %s latency: got %0d edges, expected 32 (0 = no op_done)", tag, lat);
    end
    n_vec++;
    if (result !== expected) begin
      n_bad++;
      $display("FAIL %s product: got %h, expected %h", tag, result, expected);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy_at_done: got %b, expected 0", tag, busy);
    end
    tick();
    n_vec++;
    if (op_done !== 1'b0 || busy !== 1'b0 || result !== expected) begin
      n_bad++;
      $display("FAIL %s after_done: op_done=%b busy=%b result=%h, expected 0 0 %h",
               tag, op_done, busy, result, expected);
    end
    last_result = expected;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    op_start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    tick();
    tick();
    reset = 1'b0;
    n_vec++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    n_vec++;
    if (op_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b, expected 0", op_done); end
    n_vec++;
    if (result !== 64'd0) begin n_bad++; $display("FAIL reset_result: got %h, expected 0", result); end
    last_result = '0;
  endtask

  task automatic test_basic();
    run_op(32'd7, 32'd6, "basic_7x6");
    n_vec++;
    if (result !== 64'd42) begin n_bad++; $display("FAIL basic_42: got %0d, expected 42", result); end
  endtask

  task automatic test_corners();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max_x_max");
    n_vec++;
    if (result !== 64'hFFFF_FFFE_0000_0001) begin
      n_bad++;
      $display("FAIL max_product: got %h, expected fffffffe00000001", result);
    end
    run_op(32'h1234_5678, 32'd0, "a_x_zero");
    run_op(32'd0, 32'h9ABC_DEF0, "zero_x_b");
    run_op(32'd1, 32'hDEAD_BEEF, "one_x_b");
    run_op(32'h8000_0000, 32'h8000_0000, "msb_x_msb");
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) run_op($urandom, $urandom, "random");
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    multiplicand = 32'd3;
    multiplier   = 32'd5;
    op_start     = 1'b1;
    tick();
    multiplicand = 32'd10;
    multiplier   = 32'd10;
    t1 = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (op_done === 1'b1) begin t1 = i; break; end
    end
    n_vec++;
    if (t1 != 32 || result !== 64'd15) begin
      n_bad++;
      $display("FAIL b2b_first: latency=%0d result=%0d, expected 32 and 15", t1, result);
    end
    t2 = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (op_done === 1'b1) begin t2 = i; break; end
    end
    n_vec++;
    if (t2 != 33 || result !== 64'd100) begin
      n_bad++;
      $display("FAIL b2b_second: gap=%0d result=%0d, expected 33 and 100", t2, result);
    end
    op_start = 1'b0;
    tick();
    n_vec++;
    if (op_done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_idle: op_done=%b busy=%b, expected 0 0", op_done, busy);
    end
    last_result = 64'd100;
  endtask

  task automatic test_reset_mid_op();
    bit spurious;
    multiplicand = 32'd100;
    multiplier   = 32'd200;
    op_start     = 1'b1;
    tick();
    op_start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || op_done !== 1'b0 || result !== 64'd0) begin
      n_bad++;
      $display("FAIL midreset_state: busy=%b op_done=%b result=%h, expected 0 0 0",
               busy, op_done, result);
    end
    last_result = '0;
    spurious = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (op_done !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
    end
    n_vec++;
    if (spurious) begin n_bad++; $display("FAIL midreset_quiet: got activity after reset, expected none"); end
    run_op(32'd13, 32'd11, "after_reset_13x11");
    n_vec++;
    if (result !== 64'd143) begin n_bad++; $display("FAIL after_reset_143: got %0d, expected 143", result); end
  endtask

  task automatic test_reset_with_start();
    multiplicand = 32'd9;
    multiplier   = 32'd9;
    op_start     = 1'b1;
    reset        = 1'b1;
    tick();
    op_start = 1'b0;
    reset    = 1'b0;
    tick();
    n_vec++;
    if (busy !== 1'b0 || op_done !== 1'b0 || result !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_wins: busy=%b op_done=%b result=%h, expected 0 0 0", busy, op_done, result);
    end
    last_result = '0;
  endtask

  task automatic test_factorial();
    logic [63:0] acc;
    acc = 64'd1;
    for (int n = 12; n >= 1; n--) begin
      run_op(acc[31:0], 32'(n), "factorial_step");
      acc = acc * 64'(n);
    end
    n_vec++;
    if (result !== 64'd479001600) begin
      n_bad++;
      $display("FAIL factorial_12: got %0d, expected 479001600", result);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    test_reset_with_start();
    test_factorial();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mul32_seq

// File: doc/mul32_seq.md
Name: mul32_seq

Overview:
- Sequential radix-2 shift-and-add 32x32 unsigned multiplier, one partial-product add per clock.
- It is the neighbouring stage of the 32-bit carry look-ahead adder. It holds the operand and accumulator registers that feed the adder, and it consumes the adder's 32-bit sum and carry-out each cycle.
- The factorial controller uses it to form each running product n*(n-1)*... and talks to it through a start/done handshake.

Parameters:
- none. Operand width is fixed at 32 by the adder and the product is 64 bits. Iteration count MUL_ITER = 32 comes from the shared package.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- op_start  input  1  request; sampled on clk only while not busy.
- multiplicand  input  32  operand A, captured on the accepted op_start edge.
- multiplier  input  32  operand B, captured on the accepted op_start edge.
- result  output  64  unsigned product A*B; registered, held stable until the next accepted op_start.
- op_done  output  1  registered one-cycle pulse marking that result is valid.
- busy  output  1  high while an operation is in progress.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - state = IDLE.
  - result = 0.
  - op_done = 0.
  - busy = 0.
  - count = 0.
  - internal multiplicand register = 0.
  - internal product register P[64:0] = 0.
- States:
  - IDLE: busy=0. On an op_start=1 edge, go to EXEC with the following loads:
    - A_reg <= multiplicand.
    - P <= {33'b0, multiplier}.
    - count <= 0.
  - EXEC: busy=1. Each edge performs one iteration:
    - If P[0]=1: {c, s} = P[63:32] + A_reg using the adder (ci=0), then P <= {1'b0, c, s, P[31:1]}.
    - If P[0]=0: P <= P >> 1 (zero fill).
    - count increments. On the edge where count==31, the state goes to DONE.
    - On that same edge, result <= final P[63:0] and op_done <= 1.
  - DONE: busy=0 and op_done=1 for exactly one cycle.
    - Next edge: op_done <= 0.
    - With op_start=1: go to EXEC, loading as in IDLE (back-to-back operation).
    - Otherwise: go to IDLE.
- Latency: exactly 32 edges after the edge that sampled op_start. Throughput is one operation per 33 cycles when back-to-back.
- op_start while busy=1 (EXEC) is ignored. There is no queuing and the operands are not re-captured.
- Operand inputs are don't-care except on the accepting edge. Changing them mid-operation has no effect.
- result is updated only on the final EXEC edge and never shows partial products.
- Arithmetic: the adder carry-out becomes bit 63 of the shifted accumulator, so there is no overflow loss. The full 64-bit product is exact for all inputs, including 0xFFFFFFFF*0xFFFFFFFF.
- Reset mid-operation: reset takes priority over everything else. On the next edge the block is in IDLE, the outputs take their reset values, and the partial product is discarded.
- Simultaneous reset and op_start: reset wins and the request is lost.

Decomposition:
- Shared package (mul_pkg):
  - State encodings ST_IDLE=2'd0, ST_EXEC=2'd1, ST_DONE=2'd2.
  - MUL_ITER=32.
  - CNT_W=5.
- Sub-module: one instance of the existing cla32 adder, with ci tied to 0, a = P[63:32], b = A_reg.
- The FSM, counter and shift register remain inline in mul32_seq.

Test Plan:
- Reset for 2 cycles, then A=7, B=6, pulse op_start -> op_done pulses exactly 32 cycles later, result=64'd42, busy high for cycles 1..32.
- A=0xFFFFFFFF, B=0xFFFFFFFF -> result=64'hFFFFFFFE_00000001 and op_done is a single-cycle pulse.
- A=0x12345678, B=0 and then A=0, B=0x9ABCDEF0 -> result=0 in both cases with latency still 32 cycles.
- Hold op_start=1 continuously: first A=3, B=5; operands are changed to A=10, B=10 during EXEC.
  - The extra start edges are ignored and the first result is 15.
  - The second operation starts from DONE with A=10, B=10 and yields 100, done 33 cycles after the first done.
- Reset asserted at EXEC cycle 10 of A=100, B=200 -> next edge: busy=0, op_done=0, result=0; no op_done pulse follows.
  - A new op_start with A=13, B=11 then yields 143.
- Factorial chain: drive successive products for 12! (the prior result's lower 32 bits fed back as A, B decremented 12..1) -> final result=479001600.
